// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with show-ahead or registered read, fill level and thresholds.
// Define SFIFO_PARAM_ERRFLAG_EN to build the sticky OVF/UDF flags cleared by ERR_CLR.
module sfifo_param #(
  parameter int WIDTH  = 8,
  parameter int AW     = 10,
  parameter int FWFT   = 1,
  parameter int AF_LVL = 2**AW - 1,
  parameter int AE_LVL = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             WR,
  input  logic             RD,
  output logic [WIDTH-1:0] Q,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [AW:0]      LEVEL,
  output logic             OVF,
  output logic             UDF,
  input  logic             ERR_CLR
);

  localparam int DEPTH = 2**AW;

  logic [AW:0]      wcnt_q, wcnt_d;
  logic [AW:0]      rcnt_q, rcnt_d;
  logic [AW:0]      level;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_acc, rd_acc;

  // Status is decoded from the pointers only, so it never depends on WR/RD/D.
  assign level  = wcnt_q - rcnt_q;
  assign LEVEL  = level;
  assign FULL   = (level == (AW+1)'(DEPTH));
  assign EMPTY  = (level == '0);
  assign AFULL  = (level >= (AW+1)'(AF_LVL));
  assign AEMPTY = (level <= (AW+1)'(AE_LVL));

  assign wr_acc = WR & ~FULL;
  assign rd_acc = RD & ~EMPTY;

  always_comb begin
    wcnt_d = wcnt_q + {{AW{1'b0}}, wr_acc};
    rcnt_d = rcnt_q + {{AW{1'b0}}, rd_acc};
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST && !FLUSH) begin
      mem_q[wcnt_q[AW-1:0]] <= D;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign Q = mem_q[rcnt_q[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
          q_q <= '0;
        end else if (rd_acc) begin
          q_q <= mem_q[rcnt_q[AW-1:0]];
        end
      end
      assign Q = q_q;
    end
  endgenerate

`ifdef SFIFO_PARAM_ERRFLAG_EN
  logic ovf_q, udf_q;

  // A set event in the same cycle as ERR_CLR wins; FLUSH leaves the flags alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (!FLUSH && WR && FULL) begin
        ovf_q <= 1'b1;
      end else if (ERR_CLR) begin
        ovf_q <= 1'b0;
      end
      if (!FLUSH && RD && EMPTY) begin
        udf_q <= 1'b1;
      end else if (ERR_CLR) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: show-ahead instance (WIDTH=8, AW=2, AF=3, AE=1) plus a registered-read instance.
module tb_sfifo_param;

`ifdef SFIFO_PARAM_ERRFLAG_EN
  localparam logic EF = 1'b1;
`else
  localparam logic EF = 1'b0;
`endif

  logic       clk = 1'b0;
  int         total = 0;
  int         bad = 0;

  // show-ahead instance
  logic       rst, flush, wr, rd, err_clr;
  logic [7:0] d, q;
  logic       full, empty, afull, aempty, ovf, udf;
  logic [2:0] level;

  // registered-read instance
  logic       rst0, flush0, wr0, rd0, err_clr0;
  logic [7:0] d0, q0;
  logic       full0, empty0, afull0, aempty0, ovf0, udf0;
  logic [2:0] level0;

  always #5 clk = ~clk;

  sfifo_param #(.WIDTH(8), .AW(2), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) u_dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .D(d), .WR(wr), .RD(rd), .Q(q),
    .FULL(full), .EMPTY(empty), .AFULL(afull), .AEMPTY(aempty), .LEVEL(level),
    .OVF(ovf), .UDF(udf), .ERR_CLR(err_clr)
  );

  sfifo_param #(.WIDTH(8), .AW(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) u_dut0 (
    .CLK(clk), .RST(rst0), .FLUSH(flush0), .D(d0), .WR(wr0), .RD(rd0), .Q(q0),
    .FULL(full0), .EMPTY(empty0), .AFULL(afull0), .AEMPTY(aempty0), .LEVEL(level0),
    .OVF(ovf0), .UDF(udf0), .ERR_CLR(err_clr0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_dat [4];
    logic [7:0] val;
    fill_dat[0] = 8'h11; fill_dat[1] = 8'h22; fill_dat[2] = 8'h33; fill_dat[3] = 8'h44;

    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; d = 8'h00;
    rst0 = 1'b1; flush0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; err_clr0 = 1'b0; d0 = 8'h00;
    tick();
    rst = 1'b0; rst0 = 1'b0;

    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_q0", q0, 8'h00);

    // fill
    for (int i = 0; i < 4; i++) begin
      d = fill_dat[i]; wr = 1'b1;
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_aempty", aempty, (i + 1) <= 1);
      chk("fill_afull", afull, (i + 1) >= 3);
      chk("fill_full", full, (i + 1) == 4);
    end
    d = 8'h55;
    tick();
    wr = 1'b0;
    chk("ovf_level", level, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag", ovf, EF);

    // drain
    for (int i = 0; i < 4; i++) begin
      chk("drain_q", q, fill_dat[i]);
      rd = 1'b1;
      tick();
      chk("drain_level", level, 3 - i);
    end
    rd = 1'b0;
    chk("drain_empty", empty, 1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("udf_level", level, 0);
    chk("udf_flag", udf, EF);
    chk("udf_ovf_kept", ovf, EF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_udf", udf, 0);

    // wrap: pointers cross the modulo-8 boundary several times
    val = 8'h01;
    for (int r = 0; r < 10; r++) begin
      wr = 1'b1;
      for (int k = 0; k < 3; k++) begin
        d = val + 8'(k);
        tick();
        chk("wrap_full", full, 0);
      end
      wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("wrap_q", q, val + 8'(k));
        rd = 1'b1;
        tick();
      end
      rd = 1'b0;
      chk("wrap_empty", empty, 1);
      val = val + 8'd3;
    end

    // simultaneous WR+RD at LEVEL=2
    wr = 1'b1;
    d = 8'hA0; tick();
    d = 8'hA1; tick();
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("sim_q", q, 8'hA0 + 8'(i));
      d = 8'hA2 + 8'(i);
      tick();
      chk("sim_level", level, 2);
    end
    wr = 1'b0;
    chk("sim_head", q, 8'hA5);
    tick();
    chk("sim_next", q, 8'hA6);
    tick();
    rd = 1'b0;
    chk("sim_drained", level, 0);

    // WR+RD while empty: write taken, read ignored
    wr = 1'b1; rd = 1'b1; d = 8'hB0;
    tick();
    rd = 1'b0;
    chk("e_wrrd_level", level, 1);
    chk("e_wrrd_q", q, 8'hB0);
    chk("e_wrrd_udf", udf, EF);
    d = 8'hB1; tick();
    d = 8'hB2; tick();
    d = 8'hB3; tick();
    chk("f_level", level, 4);
    // WR+RD while full: read taken, write dropped
    rd = 1'b1; d = 8'hB4;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("f_wrrd_level", level, 3);
    chk("f_wrrd_ovf", ovf, EF);
    for (int i = 0; i < 3; i++) begin
      chk("f_wrrd_q", q, 8'hB1 + 8'(i));
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("f_wrrd_empty", empty, 1);

    // flush at LEVEL=3 keeps flags
    wr = 1'b1;
    d = 8'hC0; tick();
    d = 8'hC1; tick();
    d = 8'hC2; tick();
    wr = 1'b0;
    chk("pre_flush_level", level, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", ovf, EF);

    // reset with a concurrent write at LEVEL=2
    wr = 1'b1;
    d = 8'hD0; tick();
    d = 8'hD1; tick();
    chk("pre_rst_level", level, 2);
    rst = 1'b1; d = 8'hEE;
    tick();
    rst = 1'b0; wr = 1'b0;
    chk("rst2_level", level, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_ovf", ovf, 0);
    chk("rst2_udf", udf, 0);
    wr = 1'b1; d = 8'h77;
    tick();
    wr = 1'b0;
    chk("post_rst_q", q, 8'h77);
    chk("post_rst_level", level, 1);

    // registered-read instance
    wr0 = 1'b1;
    d0 = 8'hA5; tick();
    d0 = 8'h5A; tick();
    wr0 = 1'b0;
    chk("reg_q_idle", q0, 8'h00);
    chk("reg_level", level0, 2);
    tick();
    chk("reg_q_hold0", q0, 8'h00);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("reg_q_rd1", q0, 8'hA5);
    tick();
    chk("reg_q_hold1", q0, 8'hA5);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("reg_q_rd2", q0, 8'h5A);
    tick();
    tick();
    chk("reg_q_hold2", q0, 8'h5A);
    chk("reg_empty", empty0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
